// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: control bus between the miniRISC multi-cycle controller and its datapath.
//   master (controller): drives wb_sel, pc_sel, alu_src, reg_we, mem_re, mem_we, ir_we, pc_we,
//                        halted, state; receives instr_class, branch_taken, mem_ready.
//   slave  (datapath/decoder/memory side): the mirror image.
interface multicycle_ctrl_if;
    logic [2:0] instr_class;
    logic       branch_taken;
    logic       mem_ready;
    logic [1:0] wb_sel;
    logic [1:0] pc_sel;
    logic       alu_src;
    logic       reg_we;
    logic       mem_re;
    logic       mem_we;
    logic       ir_we;
    logic       pc_we;
    logic       halted;
    logic [2:0] state;

    modport master (
        input  instr_class, branch_taken, mem_ready,
        output wb_sel, pc_sel, alu_src, reg_we, mem_re, mem_we, ir_we, pc_we, halted, state
    );

    modport slave (
        output instr_class, branch_taken, mem_ready,
        input  wb_sel, pc_sel, alu_src, reg_we, mem_re, mem_we, ir_we, pc_we, halted, state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB control FSM for the miniRISC multi-cycle core.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset; forces every output to 0 in the cycle it is high
//   bus  : multicycle_ctrl_if.master
//          in  instr_class (valid in DECODE), branch_taken (valid in EXEC), mem_ready
//          out wb_sel, pc_sel, alu_src, reg_we, mem_re, mem_we, ir_we, pc_we, halted, state
//   Optional: define MCTRL_MEM_TIMEOUT_EN to abort to ERROR after TIMEOUT_CYCLES cycles of
//   mem_ready low in FETCH or MEM.
module multicycle_ctrl #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TO_W           = 5
) (
    input  logic                clk,
    input  logic                rst,
    multicycle_ctrl_if.master   bus
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_ERROR  = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        C_ALU_R  = 3'd0,
        C_ALU_I  = 3'd1,
        C_LOAD   = 3'd2,
        C_STORE  = 3'd3,
        C_BRANCH = 3'd4,
        C_JAL    = 3'd5,
        C_HALT   = 3'd6,
        C_NOP    = 3'd7
    } class_e;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= (1 << TO_W)) begin : g_bad_cfg
        $error("multicycle_ctrl: TO_W too narrow for TIMEOUT_CYCLES");
    end

    state_e state_q;
    class_e class_q;

`ifdef MCTRL_MEM_TIMEOUT_EN
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] cnt_q;
    // cnt_q counts completed wait cycles, so this is the TIMEOUT_CYCLES-th one still unanswered
    logic to_hit;
    assign to_hit = (cnt_q == TO_LAST) && !bus.mem_ready;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            class_q <= C_NOP;
`ifdef MCTRL_MEM_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (bus.mem_ready)
                        state_q <= S_DECODE;
`ifdef MCTRL_MEM_TIMEOUT_EN
                    else if (to_hit)
                        state_q <= S_ERROR;
`endif
                end
                S_DECODE: begin
                    class_q <= class_e'(bus.instr_class);
                    state_q <= (bus.instr_class == C_NOP)  ? S_FETCH :
                               (bus.instr_class == C_HALT) ? S_HALT  : S_EXEC;
                end
                S_EXEC: begin
                    state_q <= (class_q == C_BRANCH) ? S_FETCH :
                               (class_q == C_LOAD || class_q == C_STORE) ? S_MEM : S_WB;
                end
                S_MEM: begin
                    if (bus.mem_ready)
                        state_q <= (class_q == C_LOAD) ? S_WB : S_FETCH;
`ifdef MCTRL_MEM_TIMEOUT_EN
                    else if (to_hit)
                        state_q <= S_ERROR;
`endif
                end
                S_WB:    state_q <= S_FETCH;
                default: state_q <= state_q;
            endcase
`ifdef MCTRL_MEM_TIMEOUT_EN
            // Leaving FETCH/MEM always follows mem_ready=1, so clearing here covers every entry
            cnt_q <= ((state_q == S_FETCH || state_q == S_MEM) && !bus.mem_ready) ? cnt_q + 1'b1 : '0;
`endif
        end
    end

    always_comb begin
        bus.wb_sel  = 2'd0;
        bus.pc_sel  = 2'd0;
        bus.alu_src = 1'b0;
        bus.reg_we  = 1'b0;
        bus.mem_re  = 1'b0;
        bus.mem_we  = 1'b0;
        bus.ir_we   = 1'b0;
        bus.pc_we   = 1'b0;
        bus.halted  = 1'b0;
        bus.state   = rst ? 3'd0 : state_q;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    bus.mem_re = 1'b1;
                    bus.ir_we  = bus.mem_ready;
                    bus.pc_we  = bus.mem_ready;
                end
                S_EXEC: begin
                    bus.alu_src = (class_q == C_ALU_I) || (class_q == C_LOAD) || (class_q == C_STORE);
                    bus.pc_sel  = (class_q == C_BRANCH) ? 2'd1 : (class_q == C_JAL) ? 2'd2 : 2'd0;
                    bus.pc_we   = (class_q == C_BRANCH) ? bus.branch_taken : (class_q == C_JAL);
                end
                S_MEM: begin
                    bus.mem_re = (class_q == C_LOAD);
                    bus.mem_we = (class_q == C_STORE);
                end
                S_WB: begin
                    bus.reg_we = 1'b1;
                    bus.wb_sel = (class_q == C_LOAD) ? 2'd1 : (class_q == C_JAL) ? 2'd2 : 2'd0;
                end
                S_HALT, S_ERROR: bus.halted = 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed-vector bench for multicycle_ctrl; timeout cases build with MCTRL_MEM_TIMEOUT_EN.
module tb_multicycle_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(.TIMEOUT_CYCLES(4), .TO_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_bad = 0;

    // {state, wb_sel, pc_sel, alu_src, reg_we, mem_re, mem_we, ir_we, pc_we, halted}
    logic [13:0] outs;
    assign outs = {bus.state, bus.wb_sel, bus.pc_sel, bus.alu_src, bus.reg_we,
                   bus.mem_re, bus.mem_we, bus.ir_we, bus.pc_we, bus.halted};

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    function automatic logic [13:0] o(input int st, input int wb, input int pc, input bit alu,
                                      input bit rwe, input bit mre, input bit mwe, input bit ir,
                                      input bit pcw, input bit h);
        return {st[2:0], wb[1:0], pc[1:0], alu, rwe, mre, mwe, ir, pcw, h};
    endfunction

    // check mid-cycle, then move one clock on
    task automatic step(input string tag, input logic [13:0] exp);
        #1 chk(tag, 16'(outs), 16'(exp));
        @(posedge clk);
        #1;
    endtask

    logic [13:0] f_go, f_wait, dec, zero;

    initial begin
        f_go   = o(0, 0, 0, 0, 0, 1, 0, 1, 1, 0);
        f_wait = o(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        dec    = o(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        zero   = '0;
        rst = 1'b1;
        bus.mem_ready = 1'b1;
        bus.instr_class = 3'd7;
        bus.branch_taken = 1'b0;
        @(posedge clk);
        #1;
        step("rst_out", zero);
        rst = 1'b0;
        // ALU_R
        bus.instr_class = 3'd0;
        step("alur_f", f_go);
        step("alur_d", dec);
        step("alur_e", o(2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step("alur_wb", o(4, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        // LOAD with three wait cycles in MEM
        bus.instr_class = 3'd2;
        step("ld_f", f_go);
        step("ld_d", dec);
        step("ld_e", o(2, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step("ld_wait", o(3, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        bus.mem_ready = 1'b1;
        step("ld_m", o(3, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        step("ld_wb", o(4, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        // STORE
        bus.instr_class = 3'd3;
        step("st_f", f_go);
        step("st_d", dec);
        step("st_e", o(2, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        step("st_m", o(3, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        // BRANCH taken / not taken
        bus.instr_class = 3'd4;
        bus.branch_taken = 1'b1;
        step("brt_f", f_go);
        step("brt_d", dec);
        step("brt_e", o(2, 0, 1, 0, 0, 0, 0, 0, 1, 0));
        bus.branch_taken = 1'b0;
        step("brn_f", f_go);
        step("brn_d", dec);
        step("brn_e", o(2, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        // JAL
        bus.instr_class = 3'd5;
        step("jal_f", f_go);
        step("jal_d", dec);
        step("jal_e", o(2, 0, 2, 0, 0, 0, 0, 0, 1, 0));
        step("jal_wb", o(4, 2, 0, 0, 1, 0, 0, 0, 0, 0));
        // NOP
        bus.instr_class = 3'd7;
        step("nop_f", f_go);
        step("nop_d", dec);
        // HALT absorbs until reset
        bus.instr_class = 3'd6;
        step("hlt_f", f_go);
        step("hlt_d", dec);
        bus.instr_class = 3'd0;
        for (int i = 0; i < 20; i++) step("halt", o(5, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        rst = 1'b1;
        step("hlt_rst", zero);
        rst = 1'b0;
        bus.mem_ready = 1'b0;
        step("hlt_post_f", f_wait);
        step("f_hold", f_wait);
        bus.mem_ready = 1'b1;
        // reset in the middle of a STORE
        bus.instr_class = 3'd3;
        step("st2_f", f_go);
        step("st2_d", dec);
        step("st2_e", o(2, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        bus.mem_ready = 1'b0;
        step("st2_m", o(3, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        rst = 1'b1;
        step("st2_rst", zero);
        rst = 1'b0;
        step("st2_post_f", f_wait);
`ifdef MCTRL_MEM_TIMEOUT_EN
        rst = 1'b1;
        step("to_rst", zero);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step("to_wait", f_wait);
        step("to_err", o(6, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        step("to_err_hold", o(6, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        rst = 1'b1;
        step("to_rst2", zero);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step("to_win_wait", f_wait);
        bus.mem_ready = 1'b1;
        step("to_win_f", f_go);
        step("to_win_d", dec);
`endif
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
